lcd_page_sched: RTL and testbench
=================================

LCD_PAGE_SCHED -- requirements
Module: lcd_page_sched

Interface
REQ-001 SHALL have parameter N_CLI, default 4; number of page clients; legal range 2..4.
REQ-002 SHALL have parameter DWELL, default 3; tick pulses each page is shown before rotation; legal range 1..255.
REQ-003 SHALL have port clk, input, 1; sole clock, all state on posedge.
REQ-004 SHALL have port rst, input, 1; asynchronous, active-low reset.
REQ-005 SHALL have port tick, input, 1; single-cycle dwell-time enable strobe, e.g. 1 Hz.
REQ-006 SHALL have port req, input, N_CLI; client i wants its page displayed.
REQ-007 SHALL have port urgent, input, 1; client 0 preempts rotation while urgent=1 and req[0]=1.
REQ-008 SHALL have port page_in, input, N_CLI*256.
  - Client i row1 = page_in[i*256+128 +: 128].
  - Client i row2 = page_in[i*256 +: 128].
REQ-009 SHALL have port row1_val, output, 128; ASCII row 1 to the lcd1602_drive instance.
REQ-010 SHALL have port row2_val, output, 128; ASCII row 2 to the lcd1602_drive instance.
REQ-011 SHALL have port gnt, output, N_CLI; one-hot grant, all-zero when idle.
REQ-012 SHALL have port page_sw, output, 1; one-cycle pulse when a new grant takes effect.

Function
REQ-013 SHALL implement FSM states IDLE, SWITCH and SHOW.
REQ-014 SHALL transition as follows:
  - IDLE->SWITCH when any req is high.
  - SWITCH->SHOW always, after one cycle.
  - SHOW->SWITCH on any of: dwell expiry; granted req deasserted; urgent preemption.
  - SHOW->IDLE when no req is high.
REQ-015 SWITCH SHALL pick the next requester round-robin, starting at the index after the last granted client and wrapping from N_CLI-1 to 0.
REQ-016 urgent=1 with req[0]=1 SHALL force client 0 in SWITCH, overriding round-robin.
REQ-017 On entry to SHOW, gnt SHALL update, page_sw SHALL pulse, and the dwell counter SHALL load 0.
REQ-018 In SHOW, each tick SHALL increment the dwell counter.
REQ-019 When the dwell counter reaches DWELL, rotation SHALL occur:
  - Go to SWITCH if some other client requests.
  - Otherwise restart the dwell at 0 with no page_sw pulse.
REQ-020 While urgent preemption holds client 0, the dwell counter SHALL not cause rotation.
REQ-021 If urgent and req[0] are asserted while another client is shown, SWITCH SHALL occur on the next cycle.
REQ-022 In SHOW, row1_val/row2_val SHALL register the granted client's page every cycle (1-cycle latency), so live content such as a running clock updates.
REQ-023 In IDLE, row1_val/row2_val SHALL hold 16 ASCII spaces (8'h20 repeated).
REQ-024 In SWITCH, row1_val/row2_val SHALL hold their previous values.
REQ-025 If tick coincides with a req drop in the same cycle, the req drop SHALL take precedence; the dwell counter SHALL not be incremented.
REQ-026 The dwell counter SHALL be 8 bits and SHALL not wrap past DWELL.
REQ-027 Req bits of clients i>=N_CLI SHALL not exist; there are no out-of-range grants.

Reset
REQ-028 While rst=0, outputs SHALL be:
  - state=IDLE, gnt=0, page_sw=0.
  - row1_val/row2_val = all 8'h20.
  - Dwell counter = 0.
  - Last-grant pointer = N_CLI-1, so client 0 is picked first.
REQ-029 Reset asserted mid-SHOW SHALL take effect asynchronously, with no partial-page output.
REQ-030 Operation SHALL restart on the first posedge clk after rst deasserts.

Structure
REQ-031 Shared package lcd_pkg SHALL hold ROW_W=128, PAGE_W=256, the BLANK_ROW constant and the FSM state enum.
REQ-032 Round-robin selection SHALL be in a sub-module rr_pick: N_CLI req, last pointer and force0 in; index and valid out; combinational.
REQ-033 All storage SHALL reside in lcd_page_sched.

Verification
REQ-034 Reset check: rst low, then release with req=0 -> rows=all 8'h20, gnt=0000, page_sw never pulses.
REQ-035 Rotation (DWELL=3): req=0101, tick every 10 cycles -> gnt sequence 0001, 0100, 0001; each page held for exactly 3 ticks; one page_sw per change.
REQ-036 Req drop: client 2 shown, req[2] drops mid-dwell -> SWITCH next cycle; gnt=0001 two cycles after the drop.
REQ-037 Urgent: client 1 shown, urgent=1 with req[0]=1 -> gnt=0001 within 2 cycles; holds across 10 ticks; after release, rotates to client 1.
REQ-038 Live update: client 0 page_in row1 changes from "Clock 12:00:00" to "Clock 12:00:01" -> row1_val follows 1 cycle later, no page_sw.
REQ-039 Single requester: req=0010 over 7 ticks -> gnt stays 0010, page_sw pulses once, dwell restarts silently.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD page scheduler: row/page widths, the blank
// row pattern and the scheduler state encoding.
package lcd_pkg;
  localparam int ROW_W  = 128;
  localparam int PAGE_W = 256;
  localparam int PTR_W  = 2;

  localparam logic [ROW_W-1:0] BLANK_ROW = {16{8'h20}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    SHOW   = 2'd2
  } state_e;
endpackage

// File: rtl/lcd_page_sched_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping,
// with client 0 forced when force0 and req[0] are both set.
module rr_pick
  import lcd_pkg::*;
#(
  parameter int N_CLI = 4
) (
  input  logic [N_CLI-1:0] req,
  input  logic [PTR_W-1:0] last,
  input  logic             force0,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    if (force0 && req[0]) begin
      idx   = '0;
      valid = 1'b1;
    end else begin
      // Scan farthest offset first so the nearest requester is the last write.
      for (int k = N_CLI; k >= 1; k--) begin
        if (req[(int'(last) + k) % N_CLI]) begin
          idx   = PTR_W'((int'(last) + k) % N_CLI);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_page_sched.sv
// Time-shares a 16x2 character LCD between up to four page clients with
// dwell-based rotation, request-drop switching and urgent preemption by client 0.
module lcd_page_sched
  import lcd_pkg::*;
#(
  parameter int N_CLI = 4,
  parameter int DWELL = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [N_CLI-1:0]        req,
  input  logic                    urgent,
  input  logic [N_CLI*PAGE_W-1:0] page_in,
  output logic [ROW_W-1:0]        row1_val,
  output logic [ROW_W-1:0]        row2_val,
  output logic [N_CLI-1:0]        gnt,
  output logic                    page_sw,
  output state_e                  state_dbg
);

  localparam logic [7:0]       DWELL_L = 8'(DWELL);
  localparam logic [N_CLI-1:0] ONE_L   = {{(N_CLI-1){1'b0}}, 1'b1};

  // Handshake: none; req/urgent are level requests sampled every cycle, and
  // gnt is a registered one-hot that only changes on SWITCH->SHOW or to idle.
  state_e             state_q, state_d;
  logic [N_CLI-1:0]   gnt_q, gnt_d;
  logic               page_sw_q, page_sw_d;
  logic [ROW_W-1:0]   row1_q, row1_d, row2_q, row2_d;
  logic [7:0]         dwell_q, dwell_d;
  logic [PTR_W-1:0]   last_q, last_d;
  logic [PTR_W-1:0]   cur_q, cur_d;

  logic               force0;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               others;
  logic               hold0;
  logic [7:0]         dwell_inc;
  logic               expired;

  assign force0 = urgent & req[0];
  assign others = |(req & ~gnt_q);
  assign hold0  = force0 && (cur_q == '0);

  // Saturating increment keeps the counter at DWELL while urgent holds client 0.
  assign dwell_inc = (tick && (dwell_q < DWELL_L)) ? dwell_q + 8'd1 : dwell_q;
  assign expired   = (dwell_inc >= DWELL_L);

  rr_pick #(.N_CLI(N_CLI)) u_pick (
    .req    (req),
    .last   (last_q),
    .force0 (force0),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    page_sw_d = 1'b0;
    row1_d    = row1_q;
    row2_d    = row2_q;
    dwell_d   = dwell_q;
    last_d    = last_q;
    cur_d     = cur_q;

    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        row1_d = BLANK_ROW;
        row2_d = BLANK_ROW;
        if (|req) state_d = SWITCH;
      end

      SWITCH: begin
        if (pick_vld) begin
          state_d   = SHOW;
          gnt_d     = ONE_L << pick_idx;
          page_sw_d = 1'b1;
          dwell_d   = 8'd0;
          last_d    = pick_idx;
          cur_d     = pick_idx;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          row1_d  = BLANK_ROW;
          row2_d  = BLANK_ROW;
        end
      end

      SHOW: begin
        if (!(|req)) begin
          state_d = IDLE;
          gnt_d   = '0;
          row1_d  = BLANK_ROW;
          row2_d  = BLANK_ROW;
          dwell_d = 8'd0;
        end else begin
          row1_d = page_in[int'(cur_q)*PAGE_W + ROW_W +: ROW_W];
          row2_d = page_in[int'(cur_q)*PAGE_W +: ROW_W];
          // A dropped grant or an urgent request wins over any coincident tick.
          if ((force0 && (cur_q != '0)) || !req[cur_q]) begin
            state_d = SWITCH;
          end else if (hold0) begin
            dwell_d = dwell_inc;
          end else if (expired) begin
            if (others) state_d = SWITCH;
            else        dwell_d = 8'd0;
          end else begin
            dwell_d = dwell_inc;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      page_sw_q <= 1'b0;
      row1_q    <= BLANK_ROW;
      row2_q    <= BLANK_ROW;
      dwell_q   <= 8'd0;
      last_q    <= PTR_W'(N_CLI - 1);
      cur_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      page_sw_q <= page_sw_d;
      row1_q    <= row1_d;
      row2_q    <= row2_d;
      dwell_q   <= dwell_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
    end
  end

  assign row1_val  = row1_q;
  assign row2_val  = row2_q;
  assign gnt       = gnt_q;
  assign page_sw   = page_sw_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lcd_page_sched.sv
// Scoreboard bench for lcd_page_sched: directed scenarios plus random traffic,
// all checked against a behavioural model of which page is on screen.
module tb_lcd_page_sched;
  localparam int N_CLI = 4;
  localparam int DWELL = 3;
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           tick = 1'b0;
  logic           urgent = 1'b0;
  logic [3:0]     req = 4'b0;
  logic [1023:0]  page_in = '0;
  logic [127:0]   row1_val, row2_val;
  logic [3:0]     gnt;
  logic           page_sw;
  lcd_pkg::state_e state_dbg;

  always #5 clk = ~clk;

  lcd_page_sched #(.N_CLI(N_CLI), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .req       (req),
    .urgent    (urgent),
    .page_in   (page_in),
    .row1_val  (row1_val),
    .row2_val  (row2_val),
    .gnt       (gnt),
    .page_sw   (page_sw),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int sw_seen = 0;
  logic [260:0] exp_q[$];

  // Model: which client is on screen (-1 = none) and whether a reselection is due.
  int           m_shown;
  int           m_last;
  int           m_dwell;
  bit           m_pend;
  logic [3:0]   m_gnt;
  logic         m_psw;
  logic [127:0] m_r1, m_r2;

  task automatic model_reset();
    m_shown = -1;
    m_pend  = 1'b0;
    m_last  = N_CLI - 1;
    m_dwell = 0;
    m_gnt   = 4'b0;
    m_psw   = 1'b0;
    m_r1    = BLANK;
    m_r2    = BLANK;
  endtask

  task automatic model_blank();
    m_shown = -1;
    m_gnt   = 4'b0;
    m_r1    = BLANK;
    m_r2    = BLANK;
  endtask

  task automatic model_step();
    int pick;
    int d;
    m_psw = 1'b0;
    if (m_pend) begin
      m_pend = 1'b0;
      pick = -1;
      if (urgent && req[0]) pick = 0;
      else begin
        for (int k = 1; k <= N_CLI; k++)
          if (pick < 0 && req[(m_last + k) % N_CLI]) pick = (m_last + k) % N_CLI;
      end
      if (pick < 0) model_blank();
      else begin
        m_shown = pick;
        m_last  = pick;
        m_gnt   = 4'b0001 << pick;
        m_psw   = 1'b1;
        m_dwell = 0;
      end
    end else if (m_shown < 0) begin
      model_blank();
      if (req != 4'b0) m_pend = 1'b1;
    end else if (req == 4'b0) begin
      model_blank();
    end else begin
      m_r1 = page_in[m_shown*256 + 128 +: 128];
      m_r2 = page_in[m_shown*256 +: 128];
      if ((urgent && req[0] && m_shown != 0) || !req[m_shown]) m_pend = 1'b1;
      else if (urgent && req[0]) begin
        if (tick && m_dwell < DWELL) m_dwell++;
      end else begin
        d = m_dwell + (tick ? 1 : 0);
        if (d >= DWELL) begin
          if ((req & ~(4'b0001 << m_shown)) != 4'b0) m_pend = 1'b1;
          else m_dwell = 0;
        end else m_dwell = d;
      end
    end
  endtask

  task automatic drive_cycle(input logic [3:0] r, input logic u, input logic t);
    req    = r;
    urgent = u;
    tick   = t;
    @(posedge clk);
    #1;
    model_step();
    exp_q.push_back({m_gnt, m_psw, m_r1, m_r2});
  endtask

  task automatic run(input logic [3:0] r, input logic u, input int n, input int tick_per);
    for (int i = 0; i < n; i++)
      drive_cycle(r, u, (tick_per > 0) && ((i % tick_per) == tick_per - 1));
  endtask

  task automatic rand_page(input int c);
    for (int w = 0; w < 8; w++) page_in[c*256 + w*32 +: 32] = $urandom;
  endtask

  task automatic chk(input string name, input logic [260:0] got, input logic [260:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    logic [260:0] e;
    if (rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({gnt, page_sw, row1_val, row2_val} !== e) begin
        errors++;
        $display("FAIL out_cmp t=%0t gnt=%b/%b sw=%b/%b r1=%h/%h r2=%h/%h", $time,
                 gnt, e[260:257], page_sw, e[256], row1_val, e[255:128], row2_val, e[127:0]);
      end
      if (page_sw) sw_seen++;
    end
  end

  initial begin
    logic [127:0] clk_a;
    logic [127:0] clk_b;
    int s0;
    logic [3:0] rr;
    logic uu;
    clk_a = "Clock 12:00:00";
    clk_b = "Clock 12:00:01";
    for (int c = 0; c < N_CLI; c++) rand_page(c);
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {gnt, page_sw, row1_val, row2_val}, {4'b0, 1'b0, BLANK, BLANK});
    #1 rst = 1'b1;

    run(4'b0000, 1'b0, 6, 0);
    run(4'b0101, 1'b0, 110, 10);
    run(4'b0100, 1'b0, 6, 0);
    run(4'b0001, 1'b0, 6, 0);
    run(4'b0010, 1'b0, 6, 0);
    run(4'b0011, 1'b1, 110, 10);
    run(4'b0011, 1'b0, 50, 10);

    run(4'b0001, 1'b0, 4, 0);
    page_in[128 +: 128] = clk_a;
    run(4'b0001, 1'b0, 3, 0);
    page_in[128 +: 128] = clk_b;
    s0 = sw_seen;
    run(4'b0001, 1'b0, 3, 0);
    @(negedge clk); #1;
    chk("live_no_sw", 261'(sw_seen - s0), 261'(0));
    chk("live_row1", 261'(row1_val), 261'(clk_b));

    s0 = sw_seen;
    run(4'b0010, 1'b0, 75, 10);
    @(negedge clk); #1;
    chk("single_sw", 261'(sw_seen - s0), 261'(1));
    chk("single_gnt", 261'(gnt), 261'(4'b0010));

    rr = 4'b0;
    uu = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) uu = ~uu;
      if ($urandom_range(0, 9) == 0) rand_page($urandom_range(0, N_CLI - 1));
      drive_cycle(rr, uu, $urandom_range(0, 3) == 0);
    end

    run(4'b1111, 1'b0, 10, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out", {gnt, page_sw, row1_val, row2_val}, {4'b0, 1'b0, BLANK, BLANK});
    model_reset();
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_out", {gnt, page_sw, row1_val, row2_val}, {4'b0, 1'b0, BLANK, BLANK});
    #1 rst = 1'b1;
    run(4'b1010, 1'b0, 40, 5);
    for (int i = 0; i < 500; i++)
      drive_cycle(4'($urandom_range(0, 15)), $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
